alu_seq_n_bits: RTL and testbench
=================================

ALU_SEQ_N_BITS -- requirements
Module: alu_seq_n_bits

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to launch an operation.
REQ-005 SHALL have ports a, b  input  N  operands, sampled only on an accepted start.
REQ-006 SHALL have port control  input  4  opcode, sampled only on an accepted start.
REQ-007 SHALL have port result  output  N  registered result.
REQ-008 SHALL have ports v, c, n, z  output  1 each  registered overflow, carry, negative and zero flags.
REQ-009 SHALL have port dz  output  1  registered divide-by-zero flag.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking a result/flag update.

Function
REQ-012 SHALL decode opcodes as: 0 add, 1 sub (a+~b+1), 2 and, 3 or, 4 xor, 5 logical shift right a>>b, 6 shift left a<<b, 7 unsigned mod, 8 unsigned mul, 9 unsigned div; 10-15 pass a through.
REQ-013 SHALL implement FSM states IDLE and CALC; start is accepted only in IDLE, and start in CALC is ignored with no effect.
REQ-014 SHALL, for opcodes 0-6 and 10-15, update result/flags on the accepting edge, with done=1 for the following cycle, busy=0, and the FSM remaining in IDLE.
REQ-015 SHALL, for opcodes 7, 8 and 9 with b != 0, enter CALC on the accepting edge, set busy=1, and run exactly N iterations (shift-add multiply, restoring divide), one per cycle.
REQ-016 SHALL update result/flags on the edge completing iteration N (N edges after acceptance), pulse done for the following cycle, clear busy on that same edge, and return to IDLE.
REQ-017 SHALL produce mul result = low N bits of the 2N-bit product, c=1 iff the high N bits are nonzero, and v=0.
REQ-018 SHALL produce div result = quotient and mod result = remainder, with c=0 and v=0.
REQ-019 SHALL, for opcode 7 or 9 with b == 0, skip CALC, set dz=1 with 1-cycle latency, and return result all-ones for div or a for mod.
REQ-020 SHALL set dz=0 on every other completed operation.
REQ-021 SHALL return 0 for opcode 5 or 6 when b >= N.
REQ-022 SHALL compute flags for add/sub as: c = carry-out of the N-bit adder (sub: 1 means no borrow), v = signed overflow.
REQ-023 SHALL set c=0 and v=0 for all logic, shift and pass-through opcodes.
REQ-024 SHALL compute z = (result == 0) and n = result[N-1] for every opcode.
REQ-025 SHALL hold result, flags and dz unchanged between done pulses.
REQ-026 SHALL assert done only in the single cycle after an update.

Reset
REQ-027 SHALL, while rst_n=0, immediately force result=0, v=c=n=z=0, dz=0, busy=0, done=0, state IDLE and iteration counter 0.
REQ-028 SHALL abort any in-progress CALC on reset assertion without producing a done pulse.
REQ-029 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL verify, with N=8: add 0x7F+0x01 -> result 0x80, v=1, n=1, c=0, z=0, done one cycle after start, busy never high.
REQ-031 SHALL verify: sub 0x05-0x05 -> result 0x00, z=1, c=1, v=0; sub 0x03-0x05 -> 0xFE, c=0, n=1.
REQ-032 SHALL verify: div 100/7 -> busy high 8 cycles, then result 14, done pulse; mod 100/7 -> result 2; start pulsed mid-CALC -> ignored, result unchanged.
REQ-033 SHALL verify: div 0x2A/0 -> result 0xFF, dz=1, done after 1 cycle, busy=0; a subsequent add clears dz.
REQ-034 SHALL verify: mul 0x10*0x10 -> after 8 cycles result 0x00, c=1, z=1; mul 0x0F*0x11 -> 0xFF, c=0, n=1.
REQ-035 SHALL verify: rst_n pulled low 3 cycles into a div -> all outputs 0 immediately, no done pulse; after release, add 1+1 -> result 0x02.

Source files
------------

// File: rtl/alu_seq_n_bits.sv
// Sequential N-bit ALU. Single-cycle ops (add/sub/logic/shift/pass) finish on the accepting edge.
// Mul, div and mod run N shift-add / restoring-divide iterations in CALC.
module alu_seq_n_bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic         dz,
    output logic         busy,
    output logic         done
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   acc, acc_nxt;
    logic [N-1:0]     divisor;
    logic             op_mul, op_mod;

    logic             go_multi, last_iter;
    logic [N:0]       sum_ext;
    logic [N-1:0]     r_fast, r_slow, rem_sub;
    logic             v_fast, c_fast, dz_fast, c_slow;
    logic [N:0]       mul_sum, div_shift;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign go_multi  = ((control == 4'd7) || (control == 4'd8) || (control == 4'd9)) && (b != '0);
    assign last_iter = (cnt == CNT_W'(N - 1));

    always_comb begin
        sum_ext = '0;
        r_fast  = a;
        v_fast  = 1'b0;
        c_fast  = 1'b0;
        dz_fast = 1'b0;
        case (control)
            4'd0: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                r_fast  = sum_ext[N-1:0];
                c_fast  = sum_ext[N];
                v_fast  = add_ovf(a[N-1], b[N-1], sum_ext[N-1]);
            end
            4'd1: begin
                sum_ext = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                r_fast  = sum_ext[N-1:0];
                c_fast  = sum_ext[N];
                v_fast  = add_ovf(a[N-1], ~b[N-1], sum_ext[N-1]);
            end
            4'd2: r_fast = a & b;
            4'd3: r_fast = a | b;
            4'd4: r_fast = a ^ b;
            4'd5: r_fast = (b >= N'(N)) ? '0 : (a >> b);
            4'd6: r_fast = (b >= N'(N)) ? '0 : (a << b);
            // Only reached with b == 0 for 7/8/9; nonzero b goes through CALC
            4'd7: begin
                r_fast  = a;
                dz_fast = (b == '0);
            end
            4'd8: r_fast = '0;
            4'd9: begin
                r_fast  = '1;
                dz_fast = (b == '0);
            end
            default: r_fast = a;
        endcase
    end

    // acc holds {high/remainder, low/multiplier-or-quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, divisor} : '0);
        div_shift = {acc[2*N-1:N], acc[N-1]};
        rem_sub   = div_shift[N-1:0] - divisor;
        if (op_mul)
            acc_nxt = {mul_sum, acc[N-1:1]};
        else if (div_shift >= {1'b0, divisor})
            acc_nxt = {rem_sub, acc[N-2:0], 1'b1};
        else
            acc_nxt = {div_shift[N-1:0], acc[N-2:0], 1'b0};
        r_slow = (!op_mul && op_mod) ? acc_nxt[2*N-1:N] : acc_nxt[N-1:0];
        c_slow = op_mul && (acc_nxt[2*N-1:N] != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && go_multi) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            v      <= 1'b0;
            c      <= 1'b0;
            n      <= 1'b0;
            z      <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (start && go_multi) begin
                    busy <= 1'b1;
                end else if (start) begin
                    result <= r_fast;
                    v      <= v_fast;
                    c      <= c_fast;
                    n      <= r_fast[N-1];
                    z      <= (r_fast == '0);
                    dz     <= dz_fast;
                    done   <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    cnt    <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= r_slow;
                    v      <= 1'b0;
                    c      <= c_slow;
                    n      <= r_slow[N-1];
                    z      <= (r_slow == '0);
                    dz     <= 1'b0;
                end
            end
        end
    end

    // Working registers need no reset: they are loaded on every CALC entry
    always_ff @(posedge clk) begin
        if (state == IDLE && start && go_multi) begin
            acc     <= {{N{1'b0}}, a};
            divisor <= b;
            op_mul  <= (control == 4'd8);
            op_mod  <= (control == 4'd7);
        end else if (state == CALC) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Bench for alu_seq_n_bits (N=8): arithmetic reference model checked every cycle,
// plus hand-computed literal expectations for the directed vectors.
module tb_alu_seq_n_bits;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   control = '0;
    logic [N-1:0] result;
    logic         v, c, n, z, dz, busy, done;

    alu_seq_n_bits #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .control(control),
        .result(result), .v(v), .c(c), .n(n), .z(z), .dz(dz), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       v, c, n, z, dz;
        logic [7:0] lat;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t cur      = '0;
    exp_t pend     = '0;
    logic pend_valid = 1'b0;
    int   pend_done_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic exp_t model(input int ia, input int ib, input int iop);
        exp_t e;
        int s, d, p;
        e = '0;
        e.lat = 8'd1;
        case (iop)
            0: begin
                s = ia + ib;  e.r = 8'(s % 256);  e.c = (s >= 256);
                d = sgn(ia) + sgn(ib);  e.v = (d > 127) || (d < -128);
            end
            1: begin
                s = ia + (255 - ib) + 1;  e.r = 8'(s % 256);  e.c = (s >= 256);
                d = sgn(ia) - sgn(ib);  e.v = (d > 127) || (d < -128);
            end
            2: e.r = 8'(ia & ib);
            3: e.r = 8'(ia | ib);
            4: e.r = 8'(ia ^ ib);
            5: e.r = (ib >= N) ? 8'd0 : 8'(ia >> ib);
            6: e.r = (ib >= N) ? 8'd0 : 8'((ia << ib) % 256);
            7: if (ib == 0) begin e.r = 8'(ia); e.dz = 1'b1; end
               else begin e.r = 8'(ia % ib); e.lat = 8'(N + 1); end
            8: begin
                p = ia * ib;  e.r = 8'(p % 256);  e.c = (p >= 256);
                if (ib != 0) e.lat = 8'(N + 1);
            end
            9: if (ib == 0) begin e.r = 8'hFF; e.dz = 1'b1; end
               else begin e.r = 8'(ia / ib); e.lat = 8'(N + 1); end
            default: e.r = 8'(ia);
        endcase
        e.n = e.r[7];
        e.z = (e.r == 8'd0);
        return e;
    endfunction

    // Per-cycle comparison, sampled 1 time unit after each rising edge
    initial begin
        logic exp_done, exp_busy;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            exp_done = 1'b0;
            if (!rst_n) begin
                cur = '0;
                pend_valid = 1'b0;
            end else if (pend_valid && cyc == pend_done_cyc) begin
                cur = pend;
                pend_valid = 1'b0;
                exp_done = 1'b1;
            end
            exp_busy = rst_n && pend_valid && (pend.lat > 8'd1);
            chk("result", 32'(result), 32'(cur.r));
            chk("v", 32'(v), 32'(cur.v));
            chk("c", 32'(c), 32'(cur.c));
            chk("n", 32'(n), 32'(cur.n));
            chk("z", 32'(z), 32'(cur.z));
            chk("dz", 32'(dz), 32'(cur.dz));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
        end
    end

    // Call at a falling edge; the model records the op only if the DUT is idle
    task automatic drive(input int ia, input int ib, input int iop);
        a = 8'(ia);  b = 8'(ib);  control = 4'(iop);  start = 1'b1;
        if (!pend_valid) begin
            pend = model(ia, ib, iop);
            pend_valid = 1'b1;
            pend_done_cyc = cyc + int'(pend.lat);
        end
    endtask

    task automatic issue(input int ia, input int ib, input int iop);
        @(negedge clk);
        drive(ia, ib, iop);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 40);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int ia, input int ib, input int iop, input string nm,
                       input logic [7:0] er, input int elat);
        int lat;
        issue(ia, ib, iop);
        wait_done(lat);
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_res"}, 32'(result), 32'(er));
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run(8'h7F, 8'h01, 0, "add_ovf", 8'h80, 1);
        chk("add_ovf_v", 32'(v), 32'd1);
        chk("add_ovf_n", 32'(n), 32'd1);
        chk("add_ovf_c", 32'(c), 32'd0);
        chk("add_ovf_z", 32'(z), 32'd0);

        run(5, 5, 1, "sub_eq", 8'h00, 1);
        chk("sub_eq_z", 32'(z), 32'd1);
        chk("sub_eq_c", 32'(c), 32'd1);
        chk("sub_eq_v", 32'(v), 32'd0);
        run(3, 5, 1, "sub_neg", 8'hFE, 1);
        chk("sub_neg_c", 32'(c), 32'd0);
        chk("sub_neg_n", 32'(n), 32'd1);

        run(100, 7, 9, "div", 8'd14, N + 1);
        chk("div_dz", 32'(dz), 32'd0);

        // Mod with a start pulse three cycles into CALC; the pulse must be ignored
        issue(100, 7, 7);
        @(negedge clk);  start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mod_busy_mid", 32'(busy), 32'd1);
        drive(1, 1, 0);
        wait_done(lat);
        chk("mod_lat_rest", 32'(lat), 32'd6);
        chk("mod_res", 32'(result), 32'd2);

        run(8'h2A, 0, 9, "div0", 8'hFF, 1);
        chk("div0_dz", 32'(dz), 32'd1);
        chk("div0_busy", 32'(busy), 32'd0);
        run(1, 2, 0, "add_clr", 8'h03, 1);
        chk("add_clr_dz", 32'(dz), 32'd0);
        run(8'h2A, 0, 7, "mod0", 8'h2A, 1);
        chk("mod0_dz", 32'(dz), 32'd1);

        run(8'h10, 8'h10, 8, "mul_hi", 8'h00, N + 1);
        chk("mul_hi_c", 32'(c), 32'd1);
        chk("mul_hi_z", 32'(z), 32'd1);
        run(8'h0F, 8'h11, 8, "mul_lo", 8'hFF, N + 1);
        chk("mul_lo_c", 32'(c), 32'd0);
        chk("mul_lo_n", 32'(n), 32'd1);

        run(8'hF0, 8'h3C, 2, "and", 8'h30, 1);
        run(8'hF0, 8'h0F, 3, "or", 8'hFF, 1);
        run(8'hAA, 8'hFF, 4, "xor", 8'h55, 1);
        run(8'h80, 3, 5, "shr", 8'h10, 1);
        run(8'h81, 1, 6, "shl", 8'h02, 1);
        run(8'hFF, 8, 5, "shr_big", 8'h00, 1);
        run(8'hFF, 9, 6, "shl_big", 8'h00, 1);
        run(8'hC3, 8'h11, 12, "pass", 8'hC3, 1);
        chk("pass_c", 32'(c), 32'd0);

        // Reset three cycles into a divide: outputs clear at once, no done pulse
        issue(200, 3, 9);
        @(negedge clk);  start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({v, c, n, z, dz}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0);
        wait_done(lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_res", 32'(result), 32'h02);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
